// File: rtl/request_conditioner_if.sv
// Bundle of raw sensor inputs, service feedback and conditioned request
// outputs exchanged between the intersection front end and the request
// conditioner. Clock and reset stay as plain ports on the modules.
interface request_conditioner_if;
  // Raw, asynchronous inputs
  logic       ped_button;
  logic       up_sensor;
  logic       down_sensor;
  logic       turn_sensor;
  // Service feedback from the intersection controller
  logic       pedestrian_green;
  logic       up_green;
  logic       down_green;
  logic       turn_green;
  // Conditioned requests
  logic       pedestrian_req;
  logic       up_req;
  logic       down_req;
  logic       turn_req;
  logic [3:0] req_urgent;

  // Side that drives sensors/greens and consumes requests
  modport master (
    output ped_button, up_sensor, down_sensor, turn_sensor,
    output pedestrian_green, up_green, down_green, turn_green,
    input  pedestrian_req, up_req, down_req, turn_req, req_urgent
  );

  // The conditioner itself
  modport slave (
    input  ped_button, up_sensor, down_sensor, turn_sensor,
    input  pedestrian_green, up_green, down_green, turn_green,
    output pedestrian_req, up_req, down_req, turn_req, req_urgent
  );
endinterface

// File: rtl/request_conditioner.sv
// Request conditioner: synchronises and debounces four raw sensor inputs,
// turns them into sticky service requests that hold until the matching
// green is granted, ages pending requests and flags starvation.
// Channel index: [0]=pedestrian [1]=up [2]=down [3]=turn.
module request_conditioner #(
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter int          MAX_WAIT        = 255,
  parameter int          WAIT_W          = 8,
  parameter logic [3:0]  LEVEL_MASK      = 4'b1110
) (
  input  logic                 clock,
  input  logic                 reset,
  request_conditioner_if.slave bus
);

  localparam int NCH   = 4;
  // A single-cycle debounce still needs a one-bit counter to stay legal.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [WAIT_W-1:0] AGE_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] AGE_ONE  = WAIT_W'(1);

  // Channel-vector views of the interface
  logic [NCH-1:0] raw;
  logic [NCH-1:0] green;

  assign raw   = {bus.turn_sensor, bus.down_sensor, bus.up_sensor, bus.ped_button};
  assign green = {bus.turn_green, bus.down_green, bus.up_green, bus.pedestrian_green};

  // State
  logic [NCH-1:0]    s1_q, s2_q;
  logic [NCH-1:0]    deb_q, deb_d;
  logic [NCH-1:0]    deb_prev_q;
  logic [CNT_W-1:0]  cnt_q [NCH];
  logic [CNT_W-1:0]  cnt_d [NCH];
  logic [NCH-1:0]    req_q, req_d;
  logic [WAIT_W-1:0] age_q [NCH];
  logic [WAIT_W-1:0] age_d [NCH];
  logic [NCH-1:0]    set_w;

  // Two-flop synchroniser plus the previous debounced level for edge detect
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      deb_prev_q <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples the
      // pre-edge value of its source, which is what makes s1->s2 a real chain.
      s1_q       <= raw;
      s2_q       <= s1_q;
      deb_prev_q <= deb_q;
    end
  end

  // Next-state for debounce, request and wait-age per channel
  always_comb begin
    // NOTE: every combinational output is given a default before any branch,
    // so no path leaves a value unassigned and no latch is inferred.
    deb_d = deb_q;
    req_d = req_q;
    set_w = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      age_d[i] = age_q[i];
    end

    for (int i = 0; i < NCH; i++) begin
      // Debounce: a new level must persist DEBOUNCE_CYCLES synced samples.
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end

      // Loops request while occupied; buttons request once per press.
      if (LEVEL_MASK[i]) set_w[i] = deb_q[i];
      else               set_w[i] = deb_q[i] & ~deb_prev_q[i];

      // Green grant clears and wins over a simultaneous set.
      if (green[i])      req_d[i] = 1'b0;
      else if (set_w[i]) req_d[i] = 1'b1;

      // Wait age counts only while a request is pending and unserved.
      if (!req_q[i] || green[i])  age_d[i] = '0;
      else if (age_q[i] != AGE_MAX) age_d[i] = age_q[i] + AGE_ONE;
    end
  end

  // Debounce, request and wait-age registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb_q <= '0;
      req_q <= '0;
      // NOTE: the per-channel counter arrays are control state, not storage,
      // so they are cleared by reset like any other flop.
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      deb_q <= deb_d;
      req_q <= req_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
        age_q[i] <= age_d[i];
      end
    end
  end

  // Outputs are driven purely from flops
  always_comb begin
    bus.pedestrian_req = req_q[0];
    bus.up_req         = req_q[1];
    bus.down_req       = req_q[2];
    bus.turn_req       = req_q[3];
    for (int i = 0; i < NCH; i++) begin
      bus.req_urgent[i] = req_q[i] && (age_q[i] == AGE_MAX);
    end
  end

endmodule

// File: tb/tb_request_conditioner.sv
// Directed testbench for request_conditioner: latency, debounce glitch
// rejection, green clearing for edge and level channels, wait-age
// saturation/urgent flag and asynchronous reset.
module tb_request_conditioner;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  request_conditioner_if bus ();

  request_conditioner dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [3:0] reqs;
  assign reqs = {bus.turn_req, bus.down_req, bus.up_req, bus.pedestrian_req};

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    bus.ped_button       = 1'b0;
    bus.up_sensor        = 1'b0;
    bus.down_sensor      = 1'b0;
    bus.turn_sensor      = 1'b0;
    bus.pedestrian_green = 1'b0;
    bus.up_green         = 1'b0;
    bus.down_green       = 1'b0;
    bus.turn_green       = 1'b0;

    // Reset state
    tick(3);
    check("reset_reqs", 32'(reqs), 32'h0);
    check("reset_urgent", 32'(bus.req_urgent), 32'h0);
    reset = 1'b1;
    tick(1);
    check("post_release_reqs", 32'(reqs), 32'h0);

    // Pedestrian press: request exactly 7 edges after first sample
    bus.ped_button = 1'b1;
    tick(6);
    check("ped_latency_6", 32'(bus.pedestrian_req), 32'h0);
    tick(1);
    check("ped_latency_7", 32'(bus.pedestrian_req), 32'h1);
    tick(13);
    check("ped_held", 32'(reqs), 32'h1);

    // One-cycle green while held: clear next edge, no re-request
    bus.pedestrian_green = 1'b1;
    tick(1);
    check("ped_green_clear", 32'(bus.pedestrian_req), 32'h0);
    bus.pedestrian_green = 1'b0;
    tick(10);
    check("ped_no_rerequest", 32'(bus.pedestrian_req), 32'h0);
    bus.ped_button = 1'b0;
    tick(10);
    check("ped_released", 32'(bus.pedestrian_req), 32'h0);
    bus.ped_button = 1'b1;
    tick(6);
    check("ped_repress_6", 32'(bus.pedestrian_req), 32'h0);
    tick(1);
    check("ped_repress_7", 32'(bus.pedestrian_req), 32'h1);
    bus.pedestrian_green = 1'b1;
    tick(1);
    bus.pedestrian_green = 1'b0;
    check("ped_second_clear", 32'(bus.pedestrian_req), 32'h0);
    bus.ped_button = 1'b0;
    tick(10);

    // Up sensor glitch of 3 synced cycles is rejected
    bus.up_sensor = 1'b1;
    tick(3);
    bus.up_sensor = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("up_glitch", 32'(reqs), 32'h0);
    end

    // Turn loop held through a 5-cycle green
    bus.turn_sensor = 1'b1;
    tick(7);
    check("turn_latency", 32'(bus.turn_req), 32'h1);
    bus.turn_green = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("turn_during_green", 32'(bus.turn_req), 32'h0);
    end
    bus.turn_green = 1'b0;
    tick(1);
    check("turn_rerequest", 32'(bus.turn_req), 32'h1);
    tick(254);
    check("turn_age_254", 32'(bus.req_urgent), 32'h0);
    tick(1);
    check("turn_age_255", 32'(bus.req_urgent), 32'h8);
    bus.turn_green = 1'b1;
    tick(1);
    check("turn_clear_req", 32'(reqs), 32'h0);
    check("turn_clear_urgent", 32'(bus.req_urgent), 32'h0);
    bus.turn_sensor = 1'b0;
    tick(8);
    bus.turn_green = 1'b0;
    tick(2);
    check("turn_idle", 32'(reqs), 32'h0);

    // Up request ages to saturation
    bus.up_sensor = 1'b1;
    tick(7);
    check("up_latency", 32'(reqs), 32'h2);
    tick(254);
    check("up_age_254", 32'(bus.req_urgent), 32'h0);
    tick(1);
    check("up_age_255", 32'(bus.req_urgent), 32'h2);
    tick(45);
    check("up_saturated", 32'(bus.req_urgent), 32'h2);
    bus.up_green = 1'b1;
    tick(1);
    check("up_green_req", 32'(bus.up_req), 32'h0);
    check("up_green_urgent", 32'(bus.req_urgent), 32'h0);
    bus.up_sensor = 1'b0;
    tick(8);
    bus.up_green = 1'b0;
    tick(2);
    check("up_idle", 32'(reqs), 32'h0);

    // All four pending, then asynchronous reset mid-cycle
    bus.ped_button  = 1'b1;
    bus.up_sensor   = 1'b1;
    bus.down_sensor = 1'b1;
    bus.turn_sensor = 1'b1;
    tick(7);
    check("all_pending", 32'(reqs), 32'hF);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_reqs", 32'(reqs), 32'h0);
    check("async_reset_urgent", 32'(bus.req_urgent), 32'h0);
    tick(1);
    reset = 1'b1;
    tick(6);
    check("reform_6", 32'(reqs), 32'h0);
    tick(1);
    check("reform_7", 32'(reqs), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
